// File: rtl/cla_pipe_addsub.sv
// Pipelined carry-lookahead adder/subtractor. WIDTH bits are split into SEGS
// segments built from GROUP-bit lookahead groups, one operation per cycle.
module cla_pipe_addsub #(
  parameter int WIDTH = 32,
  parameter int GROUP = 4,
  parameter int SEGS  = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int SW = WIDTH / SEGS;
  localparam int NG = SW / GROUP;

  logic             adv;
  logic [WIDTH-1:0] bx;
  logic             c0;

  logic             outValid_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;
  logic             zero_q;

  // One stall signal freezes every register, so in_ready is simply "output free".
  assign adv       = !outValid_q || out_ready;
  assign in_ready  = adv;
  assign bx        = sub ? ~b : b;
  assign c0        = cin ^ sub;

  assign out_valid = outValid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;

  // Returns {carry_out, sum} of one SW-bit segment built from GROUP-bit groups.
  function automatic logic [SW:0] claSeg(
    input logic [SW-1:0] x,
    input logic [SW-1:0] y,
    input logic          ci
  );
    logic [SW-1:0] p;
    logic [SW-1:0] g;
    logic [SW-1:0] c;
    logic [NG-1:0] gp;
    logic [NG-1:0] gg;
    logic [NG:0]   gc;
    p = x ^ y;
    g = x & y;
    for (int j = 0; j < NG; j++) begin
      gp[j] = 1'b1;
      gg[j] = 1'b0;
      for (int i = 0; i < GROUP; i++) begin
        gg[j] = g[j*GROUP+i] | (p[j*GROUP+i] & gg[j]);
        gp[j] = gp[j] & p[j*GROUP+i];
      end
    end
    // Each group carry is formed directly from group G/P terms, not rippled.
    for (int j = 0; j <= NG; j++) begin
      gc[j] = ci;
      for (int m = 0; m < j; m++) begin
        gc[j] = gg[m] | (gp[m] & gc[j]);
      end
    end
    for (int j = 0; j < NG; j++) begin
      for (int i = 0; i < GROUP; i++) begin
        c[j*GROUP+i] = gc[j];
        for (int m = 0; m < i; m++) begin
          c[j*GROUP+i] = g[j*GROUP+m] | (p[j*GROUP+m] & c[j*GROUP+i]);
        end
      end
    end
    return {gc[NG], p ^ c};
  endfunction

  // Stages 0..SEGS-2 carry the not-yet-added upper operand slices (skew) and the
  // already finished lower sum slices (deskew) alongside the segment carry.
  for (genvar k = 0; k < SEGS - 1; k++) begin : g_stg
    localparam int LW = (k + 1) * SW;
    localparam int RW = WIDTH - LW;

    logic [SW-1:0] segA;
    logic [SW-1:0] segB;
    logic          segC;
    logic          vIn;
    logic [RW-1:0] upA;
    logic [RW-1:0] upB;
    logic [LW-1:0] sumD;
    logic [SW:0]   res;

    logic          v_q;
    logic          carry_q;
    logic [LW-1:0] sum_q;
    logic [RW-1:0] aRem_q;
    logic [RW-1:0] bRem_q;

    if (k == 0) begin : g_first
      assign segA = a[SW-1:0];
      assign segB = bx[SW-1:0];
      assign segC = c0;
      assign vIn  = in_valid;
      assign upA  = a[WIDTH-1:SW];
      assign upB  = bx[WIDTH-1:SW];
      assign sumD = res[SW-1:0];
    end else begin : g_next
      assign segA = g_stg[k-1].aRem_q[SW-1:0];
      assign segB = g_stg[k-1].bRem_q[SW-1:0];
      assign segC = g_stg[k-1].carry_q;
      assign vIn  = g_stg[k-1].v_q;
      assign upA  = g_stg[k-1].aRem_q[RW+SW-1:SW];
      assign upB  = g_stg[k-1].bRem_q[RW+SW-1:SW];
      assign sumD = {res[SW-1:0], g_stg[k-1].sum_q};
    end

    assign res = claSeg(segA, segB, segC);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q     <= 1'b0;
        carry_q <= 1'b0;
        sum_q   <= '0;
        aRem_q  <= '0;
        bRem_q  <= '0;
      end else if (adv) begin
        v_q     <= vIn;
        carry_q <= res[SW];
        sum_q   <= sumD;
        aRem_q  <= upA;
        bRem_q  <= upB;
      end
    end
  end

  logic [SW-1:0]    lastA;
  logic [SW-1:0]    lastB;
  logic             lastC;
  logic             lastVin;
  logic [SW:0]      lastRes;
  logic [WIDTH-1:0] lastSum;
  logic             msbCarry;
  logic             ovfD;
  logic             zeroD;

  if (SEGS == 1) begin : g_single
    assign lastA   = a;
    assign lastB   = bx;
    assign lastC   = c0;
    assign lastVin = in_valid;
    assign lastSum = lastRes[SW-1:0];
  end else begin : g_tail
    assign lastA   = g_stg[SEGS-2].aRem_q;
    assign lastB   = g_stg[SEGS-2].bRem_q;
    assign lastC   = g_stg[SEGS-2].carry_q;
    assign lastVin = g_stg[SEGS-2].v_q;
    assign lastSum = {lastRes[SW-1:0], g_stg[SEGS-2].sum_q};
  end

  assign lastRes = claSeg(lastA, lastB, lastC);

  // Carry into the MSB is recovered from its sum bit and half-sum.
  assign msbCarry = lastA[SW-1] ^ lastB[SW-1] ^ lastRes[SW-1];
  assign ovfD     = msbCarry ^ lastRes[SW];
  assign zeroD    = (lastSum == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outValid_q <= 1'b0;
      sum_q      <= '0;
      cout_q     <= 1'b0;
      ovf_q      <= 1'b0;
      zero_q     <= 1'b0;
    end else if (adv) begin
      outValid_q <= lastVin;
      sum_q      <= lastSum;
      cout_q     <= lastRes[SW];
      ovf_q      <= ovfD;
      zero_q     <= zeroD;
    end
  end

endmodule

// File: doc/cla_pipe_addsub.md
# cla_pipe_addsub

Parametrised, pipelined carry-lookahead adder/subtractor built from GROUP-bit lookahead groups. The WIDTH-bit operation is split into SEGS pipeline segments, with the carry registered between segments. It accepts one operation per cycle over a valid/ready handshake and returns sum, carry-out, signed overflow and zero flags. It is the next-generation arithmetic core for the datapath, replacing the fixed 32-bit ripple-of-4-bit-groups adder.

## Interface
Parameters:
- WIDTH, 32: operand/result width; must be divisible by GROUP*SEGS.
- GROUP, 4: bits per lookahead group (generate/propagate computed per group).
- SEGS, 2: pipeline segments (>=1); latency = SEGS cycles; segment width SW = WIDTH/SEGS.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operation offered.
- in_ready  out  1  operation accepted when in_valid && in_ready.
- a  in  WIDTH  operand A (unsigned/two's complement).
- b  in  WIDTH  operand B.
- cin  in  1  carry-in (add) / borrow-in (sub).
- sub  in  1  0: A+B+cin; 1: A-B-cin.
- out_valid  out  1  result present.
- out_ready  in  1  result consumed when out_valid && out_ready.
- sum  out  WIDTH  result, modulo 2^WIDTH.
- cout  out  1  carry-out of MSB (for sub: 1 = no borrow).
- ovf  out  1  signed overflow.
- zero  out  1  sum == 0.

## Operation
- Effective operand: bx = sub ? ~b : b; effective carry c0 = cin ^ sub. A-B-cin = A + ~B + !cin.
- Segment k (0..SEGS-1) adds a[k*SW +: SW] + bx[k*SW +: SW] + c_k using GROUP-bit CLA groups (group P/G, lookahead carries between groups within the segment); c_{k+1} is registered.
- Skew registers delay a/bx slices of segment k by k cycles; deskew registers hold completed lower slices so all sum bits leave in the same cycle.
- Stage valid bits v[0..SEGS-1]; out_valid = v[SEGS-1].
- Global stall: adv = !out_valid || out_ready. When adv=0, every pipeline register (data, carries, valids) holds. When adv=1, all stages shift by one; v[0] <= in_valid.
- in_ready = adv (combinational from out_valid, out_ready). No bubble collapsing.
- Flags are computed in the last segment and registered with sum: cout = carry out of bit WIDTH-1; ovf = carry into bit WIDTH-1 XOR cout; zero = (sum == 0).
- Results leave in acceptance order; no drop or duplication under any out_ready pattern.
- SEGS=1: combinational CLA with a single output register, latency 1.

## Timing
- Reset (rst_n low, asynchronous): all v=0, out_valid=0, sum=0, cout=0, ovf=0, zero=0, all internal carries/skew registers 0; in_ready=1 (follows adv).
- Reset mid-operation: all in-flight operations are discarded; nothing emerges after release except newly accepted operations.
- Latency: an op accepted at edge T appears with out_valid=1 after edge T+SEGS-1 (visible SEGS cycles after the accepting cycle) if no stall occurs.
- Throughput: 1 op/cycle with out_ready held high.
- Stall: out_valid=1 && out_ready=0 holds sum/flags stable and forces in_ready=0; inputs are ignored.
- Simultaneous consume and accept (out_ready=1, in_valid=1) in the same cycle: both occur; pipeline stays full.
- Bubbles (in_valid=0 while adv=1) propagate as v=0 stages and are not compressed.
- a, b, cin and sub are sampled only on acceptance.

## Test plan
(WIDTH=32, GROUP=4, SEGS=2 unless stated)
- Add wrap: a=0xFFFFFFFF, b=0x1, cin=0, sub=0 -> sum=0x00000000, cout=1, ovf=0, zero=1, out_valid 2 cycles after acceptance.
- Signed overflow: add a=0x7FFFFFFF, b=0x1 -> sum=0x80000000, cout=0, ovf=1. Sub a=0x80000000, b=0x1, cin=0 -> sum=0x7FFFFFFF, cout=1, ovf=1.
- Subtract with borrow: a=5, b=7, cin=0, sub=1 -> sum=0xFFFFFFFE, cout=0, ovf=0. Same with cin=1 -> 0xFFFFFFFD.
- Inter-segment carry: a=0x0000FFFF, b=0x0, cin=1, sub=0 -> sum=0x00010000, cout=0, zero=0.
- Backpressure stream: 8 back-to-back random ops with out_ready low for 3 cycles mid-stream -> in_ready low exactly while stalled with out_valid=1; the 8 results match the reference model, in order, none lost or repeated.
- Reset mid-flight: assert rst_n=0 with 2 ops in flight -> out_valid=0 and sum=0 immediately (before the next edge). After release, accept a=1, b=2 -> the only output is sum=3, 2 cycles later. Repeat the random stream for SEGS=1 and SEGS=4 (GROUP=4) to confirm latency equals SEGS.
